// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory access arbiter.
// Build option: MEM_ARB_STATS_EN adds saturating grant/wait counters.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic        en
    );
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch/data grant decision with the data-streak fairness counter.
// Data wins by default; a fetch starved for STREAK_MAX data grants is forced.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STREAK_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic gnt_if,
    output logic gnt_d
);

    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] S_MAX = SW'(STREAK_MAX);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          forced;

    always_comb begin
        forced   = if_req && (streak_q == S_MAX);
        gnt_if   = arb_en && if_req && (!d_req || forced);
        gnt_d    = arb_en && d_req && !gnt_if;
        streak_d = streak_q;
        if (gnt_if) begin
            streak_d = '0;
        end else if (gnt_d) begin
            if (!if_req) begin
                streak_d = '0;
            end else if (streak_q != S_MAX) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the single-port data memory between fetch and load/store.
// Build option: MEM_ARB_STATS_EN adds stat_if_grants/stat_d_grants/stat_if_wait.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY     = 2,
    parameter int DATA_STREAK_MAX = 4,
    parameter int ADDR_W          = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_if_grants,
    output logic [31:0]       stat_d_grants,
    output logic [31:0]       stat_if_wait
`endif
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_byte_q, mem_byte_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] cap_data;
    logic              arb_en;
    logic              gnt_if;
    logic              gnt_d;

    // Gating with rst_n keeps the grant pulses low while reset is held.
    assign arb_en = rst_n && (state_q == IDLE);

    mem_arb_prio #(
        .STREAK_MAX(DATA_STREAK_MAX)
    ) u_prio (
        .clk   (clk),
        .rst_n (rst_n),
        .arb_en(arb_en),
        .if_req(if_req),
        .d_req (d_req),
        .gnt_if(gnt_if),
        .gnt_d (gnt_d)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_byte_d  = mem_byte_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        cap_data    = mem_write_q ? '0 : mem_rdata;
        unique case (state_q)
            IDLE: begin
                if (gnt_if) begin
                    owner_d     = OWN_IF;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_byte_d  = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
                    state_d     = ACCESS;
                end else if (gnt_d) begin
                    owner_d     = OWN_D;
                    mem_read_d  = !d_we;
                    mem_write_d = d_we;
                    mem_byte_d  = d_byte;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    if (owner_q == OWN_IF) begin
                        if_rdata_d  = cap_data;
                        if_rvalid_d = 1'b1;
                    end else begin
                        d_rdata_d  = cap_data;
                        d_rvalid_d = 1'b1;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_byte_d  = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_byte_q  <= mem_byte_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt    = gnt_if;
    assign d_gnt     = gnt_d;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_byte  = mem_byte_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

`ifdef MEM_ARB_STATS_EN
    logic [31:0] st_ifg_q, st_ifg_d;
    logic [31:0] st_dg_q, st_dg_d;
    logic [31:0] st_wait_q, st_wait_d;

    always_comb begin
        st_ifg_d  = sat_inc(st_ifg_q, gnt_if);
        st_dg_d   = sat_inc(st_dg_q, gnt_d);
        st_wait_d = sat_inc(st_wait_q, if_req && !gnt_if);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_ifg_q  <= '0;
            st_dg_q   <= '0;
            st_wait_q <= '0;
        end else begin
            st_ifg_q  <= st_ifg_d;
            st_dg_q   <= st_dg_d;
            st_wait_q <= st_wait_d;
        end
    end

    assign stat_if_grants = st_ifg_q;
    assign stat_d_grants  = st_dg_q;
    assign stat_if_wait   = st_wait_q;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: random + directed requests,
// a transaction-level model predicts grants, strobes and responses.
module tb_mem_access_arbiter;

    localparam int L    = 2;
    localparam int SMAX = 4;
    localparam int AW   = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic          d_byte;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_read;
    logic          mem_write;
    logic          mem_byte;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]   stat_if_grants;
    logic [31:0]   stat_d_grants;
    logic [31:0]   stat_if_wait;
    int            m_ifg, m_dg, m_wait;
`endif

    mem_access_arbiter #(
        .MEM_LATENCY    (L),
        .DATA_STREAK_MAX(SMAX),
        .ADDR_W         (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_byte   (d_byte),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_byte (mem_byte),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants(stat_if_grants),
        .stat_d_grants (stat_d_grants),
        .stat_if_wait  (stat_if_wait)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
        if (a == 18'h10) return 32'hDEADBEEF;
        return {a[13:0], a} ^ 32'h5A3C_96E1;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    typedef struct {
        bit            own_d;
        logic [AW-1:0] addr;
        bit            we;
        bit            byt;
        logic [31:0]   wdata;
        int            g;
        logic [31:0]   rdata;
    } txn_t;

    txn_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   next_free = 0;
    int   streak_m = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: predicts each cycle from the request levels.
    always @(negedge clk) begin
        txn_t t;
        bit idle_m, e_if, e_d, in_acc, in_resp;
        cyc++;
        if (!rst_n) begin
            chk("reset_outputs", 32'(|{if_gnt, d_gnt, if_rvalid, d_rvalid,
                mem_read, mem_write, mem_byte, busy, |if_rdata, |d_rdata,
                |mem_addr, |mem_wdata}), 32'd0);
            exp_q.delete();
            streak_m  = 0;
            next_free = 0;
`ifdef MEM_ARB_STATS_EN
            m_ifg = 0; m_dg = 0; m_wait = 0;
`endif
        end else begin
`ifdef MEM_ARB_STATS_EN
            chk("stat_if_grants", stat_if_grants, m_ifg);
            chk("stat_d_grants", stat_d_grants, m_dg);
            chk("stat_if_wait", stat_if_wait, m_wait);
`endif
            idle_m = (cyc >= next_free);
            e_if = idle_m && if_req && (!d_req || streak_m == SMAX);
            e_d  = idle_m && d_req && !e_if;
            chk("grant", {30'd0, if_gnt, d_gnt}, {30'd0, e_if, e_d});
`ifdef MEM_ARB_STATS_EN
            if (e_if) m_ifg++;
            if (e_d) m_dg++;
            if (if_req && !e_if) m_wait++;
`endif
            if (e_if || e_d) begin
                t.own_d = e_d;
                t.addr  = e_d ? d_addr : if_addr;
                t.we    = e_d && d_we;
                t.byt   = e_d && d_byte;
                t.wdata = d_wdata;
                t.g     = cyc;
                t.rdata = t.we ? 32'd0 : mem_fn(t.addr);
                exp_q.push_back(t);
                if (e_if) streak_m = 0;
                else if (!if_req) streak_m = 0;
                else if (streak_m < SMAX) streak_m++;
                next_free = cyc + L + 2;
            end
            in_acc  = 0;
            in_resp = 0;
            if (exp_q.size() > 0 && cyc > exp_q[0].g) begin
                t = exp_q[0];
                if (cyc <= t.g + L) in_acc = 1;
                else in_resp = 1;
            end
            chk("busy", 32'(busy), 32'(in_acc || in_resp));
            chk("mem_read", 32'(mem_read), 32'(in_acc && !t.we));
            chk("mem_write", 32'(mem_write), 32'(in_acc && t.we));
            if (in_acc) begin
                chk("mem_addr", 32'(mem_addr), 32'(t.addr));
                chk("mem_byte", 32'(mem_byte), 32'(t.byt));
                if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
            end
            chk("if_rvalid", 32'(if_rvalid), 32'(in_resp && !t.own_d));
            chk("d_rvalid", 32'(d_rvalid), 32'(in_resp && t.own_d));
            if (in_resp) begin
                if (t.own_d) chk("d_rdata", d_rdata, t.rdata);
                else chk("if_rdata", if_rdata, t.rdata);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fetch_req(input logic [AW-1:0] a, input int hold,
                             output bit got);
        got     = 0;
        if_req  = 1'b1;
        if_addr = a;
        for (int i = 0; i < hold && !got; i++) begin
            @(negedge clk);
            if (if_gnt) got = 1;
            tick(1);
        end
        if_req  = 1'b0;
        if_addr = AW'($urandom);
    endtask

    task automatic data_req(input bit we, input bit byt,
                            input logic [AW-1:0] a, input logic [31:0] wd,
                            input int hold, output bit got,
                            output time gt);
        got     = 0;
        gt      = 0;
        d_req   = 1'b1;
        d_we    = we;
        d_byte  = byt;
        d_addr  = a;
        d_wdata = wd;
        for (int i = 0; i < hold && !got; i++) begin
            @(negedge clk);
            if (d_gnt) begin
                got = 1;
                gt  = $time;
            end
            tick(1);
        end
        d_req   = 1'b0;
        d_we    = 1'(  $urandom);
        d_byte  = 1'($urandom);
        d_addr  = AW'($urandom);
        d_wdata = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bit  got;
        time t0, t1;
        int  n;
        bit  seq[10];
        bit  exp_seq[10];
        bit  if_pend, d_pend;
        rst_n = 1'b0;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_byte = 0; d_addr = '0; d_wdata = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        fetch_req(18'h10, 50, got);
        chk("single_fetch_gnt", 32'(got), 32'd1);
        tick(5);

        data_req(1, 1, 18'h3, 32'hAB, 50, got, t0);
        chk("byte_store_gnt", 32'(got), 32'd1);
        tick(5);

        fork
            data_req(0, 0, 18'h0, 32'd0, 50, got, t0);
        join
        data_req(0, 0, 18'h4, 32'd0, 50, got, t1);
        chk("b2b_gnt", 32'(got), 32'd1);
        chk("b2b_spacing", 32'((t1 - t0) / 10), 32'(L + 2));
        tick(5);

        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        if_req = 1; if_addr = AW'($urandom);
        d_req = 1; d_we = 0; d_byte = 0; d_addr = AW'($urandom);
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if_pend = if_gnt;
            d_pend  = d_gnt;
            if (if_gnt) begin seq[n] = 0; n++; end
            else if (d_gnt) begin seq[n] = 1; n++; end
            tick(1);
            if (if_pend) if_addr = AW'($urandom);
            if (d_pend) begin
                d_addr = AW'($urandom);
                d_we   = 1'($urandom);
            end
        end
        if_req = 0; d_req = 0;
        chk("contention_count", 32'(n), 32'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("contention_seq%0d", i), 32'(seq[i]),
                32'(exp_seq[i]));
        tick(6);

        fork
            begin
                bit g;
                repeat (40) begin
                    tick($urandom_range(0, 6));
                    if ($urandom_range(0, 9) == 0) begin
                        fetch_req(AW'($urandom), $urandom_range(1, 3), g);
                    end else begin
                        fetch_req(AW'($urandom), 200, g);
                        chk("rand_fetch_served", 32'(g), 32'd1);
                    end
                end
            end
            begin
                bit  g;
                time tt;
                repeat (60) begin
                    tick($urandom_range(0, 4));
                    data_req(1'($urandom), 1'($urandom), AW'($urandom),
                             $urandom, 200, g, tt);
                    chk("rand_data_served", 32'(g), 32'd1);
                end
            end
        join
        tick(6);

        data_req(0, 0, 18'h20, 32'd0, 50, got, t0);
        chk("rst_test_gnt", 32'(got), 32'd1);
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_read_drop", 32'(mem_read), 32'd0);
        chk("rst_busy_drop", 32'(busy), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        data_req(0, 0, 18'h20, 32'd0, 50, got, t0);
        chk("reissue_gnt", 32'(got), 32'd1);
        tick(6);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
